pipe_track: RTL
===============

# pipe_track

Parametrised N-stage in-order pipeline tracker with a valid/allowin handshake at every stage. Each stage holds a payload and destination-register tag. The block also answers register-hazard queries against all in-flight entries. It generalises the fixed IF→ID→EXE→MEM→WB valid/allowin chain and the per-stage wnum/write_type hazard fan-in into one reusable block, so the decode stage can query every in-flight writer through a single interface.

## Interface
- STAGES, 4, number of pipeline stages (2..8); stage 0 is youngest.
- WIDTH, 64, payload bits per entry.
- NREAD, 2, number of hazard query ports.
- SW, $clog2(STAGES), stage-index width (derived).
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset. Asynchronous, active-high: it clears state immediately, independent of clk.
- flush  in  1  synchronous kill of all in-flight entries.
- in_valid  in  1  upstream entry offered.
- in_allowin  out  1  stage 0 can accept this cycle.
- in_data  in  WIDTH  payload.
- in_wen  in  1  entry writes a register.
- in_wnum  in  5  destination register number.
- in_rdy_stage  in  SW  first stage index at which the result is forwardable.
- stage_stall  in  STAGES  per-stage hold; bit k set means stage k is not ready_go.
- out_valid  out  1  stage STAGES-1 holds a valid entry.
- out_allowin  in  1  downstream accepts.
- out_data / out_wen / out_wnum  out  WIDTH/1/5  oldest entry fields.
- rd_num  in  5*NREAD  query register numbers, port i at [5i+4:5i].
- hit  out  NREAD  an in-flight writer to rd_num[i] exists.
- hit_stage  out  SW*NREAD  stage of the youngest matching writer.
- stall_req  out  NREAD  youngest match not yet forwardable.
- occ  out  SW+1  registered count of valid stages.

## Operation
- Per stage k: valid_k, data_k, wen_k, wnum_k, rdy_k.
- ready_go_k = ~stage_stall[k].
- allowin_k = ~valid_k | (ready_go_k & allowin_{k+1}). allowin_STAGES = out_allowin.
- in_allowin = allowin_0 & ~flush.
- out_valid = valid_{N-1} & ready_go_{N-1}.
- Stage 0 update when allowin_0: valid_0 <= in_valid & ~flush. Payload is loaded only when in_valid=1.
- Stage k>0 update when allowin_k: valid_k <= valid_{k-1} & ready_go_{k-1}. Payload is loaded only on that transfer. Otherwise all fields hold.
- Flush takes priority: all valid_k <= 0 next cycle. Payload registers are don't-care. The input is not accepted during flush.
- Output transfer: out_valid & out_allowin.
- Hazard query, per port i, combinational from registered state:
  - Match at stage k = valid_k & wen_k & (wnum_k == rd_num[i]) & (rd_num[i] != 0).
  - The lowest k wins.
  - hit = any match. hit_stage = winning k, or 0 if no hit.
  - stall_req = hit & (rdy_k > k) at the winning stage.
  - Register 0 never hits.
- occ <= popcount of next-cycle valid vector. It reads 0 on the cycle after a flush.

## Timing
- Reset values: all valid_k=0, payload/tag registers 0. Outputs: in_allowin=1 (when flush=0), out_valid=0, out_data=0, out_wen=0, out_wnum=0, hit=0, hit_stage=0, stall_req=0, occ=0.
- Latency: entry accepted at edge t appears with out_valid=1 in the cycle after edge t+STAGES-1, with no stalls.
- Throughput: 1 entry/cycle sustained.
- Full pipe with out_allowin=1: accepting a new entry and retiring the oldest in the same cycle is legal. occ is unchanged.
- in_allowin depends combinationally on out_allowin and stage_stall. No path from in_valid to in_allowin is permitted.
- A stalled stage k holds its entry. Stages above k keep draining. Stages below k fill bubbles, then back up.
- Hazard outputs reflect state after the last edge. An entry accepted this cycle is not visible to queries until the next cycle.
- rst asserted mid-operation: all entries discarded immediately. The first accept after release behaves as if from the empty state.

## Test plan
- STAGES=4: feed data 0x11,0x22,0x33 on consecutive cycles with out_allowin=1 → out_data 0x11,0x22,0x33 on cycles 4,5,6 after the first accept; occ peaks at 3.
- Hold out_allowin=0, push 5 entries → 4 accepted, in_allowin=0 after the 4th, occ=4. Then raise out_allowin with in_valid=1 → simultaneous accept and retire each cycle, occ stays 4.
- stage_stall[1]=1 for 3 cycles with a continuous stream → stage 1 entry holds, stage 2 shows bubbles, stages 0/1 fill, in_allowin=0 once stage 0 backs up. Release → order preserved, no loss or duplication.
- Entries wnum=5 (rdy_stage=2) at stage 0 and wnum=5 (rdy_stage=0) at stage 2; query rd_num=5 → hit=1, hit_stage=0, stall_req=1. After one cycle advance → hit_stage=1, stall_req=1. After another cycle → hit_stage=2, stall_req=0. rd_num=0 → hit=0.
- Full pipe, pulse flush with in_valid=1 → in_allowin=0 that cycle, next cycle out_valid=0, occ=0, all hit=0.
- Assert rst asynchronously between edges with 3 entries in flight → out_valid and occ drop to 0 before the next edge; the first post-reset entry emerges after 4 cycles.

Source files
------------

// File: rtl/pipe_track.sv
// N-stage in-order pipeline tracker with valid/allowin handshaking per stage
// and register-hazard lookup against every in-flight writer.
module pipe_track #(
    parameter int STAGES = 4,
    parameter int WIDTH  = 64,
    parameter int NREAD  = 2,
    parameter int SW     = $clog2(STAGES)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_allowin,
    input  logic [WIDTH-1:0]      in_data,
    input  logic                  in_wen,
    input  logic [4:0]            in_wnum,
    input  logic [SW-1:0]         in_rdy_stage,
    input  logic [STAGES-1:0]     stage_stall,
    output logic                  out_valid,
    input  logic                  out_allowin,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_wen,
    output logic [4:0]            out_wnum,
    input  logic [5*NREAD-1:0]    rd_num,
    output logic [NREAD-1:0]      hit,
    output logic [SW*NREAD-1:0]   hit_stage,
    output logic [NREAD-1:0]      stall_req,
    output logic [SW:0]           occ
);

    logic [STAGES-1:0] valid_r;
    logic [WIDTH-1:0]  data_r [STAGES];
    logic              wen_r  [STAGES];
    logic [4:0]        wnum_r [STAGES];
    logic [SW-1:0]     rdy_r  [STAGES];

    logic [STAGES-1:0] go_s;
    logic [STAGES-1:0] allowin_s;
    logic [STAGES-1:0] up_s;
    logic [STAGES-1:0] load_s;
    logic [STAGES-1:0] nxt_valid_s;
    logic              chain_s;

    function automatic logic [SW:0] popcount(input logic [STAGES-1:0] v);
        logic [SW:0] cnt;
        cnt = '0;
        for (int k = 0; k < STAGES; k++) begin
            cnt = cnt + {{SW{1'b0}}, v[k]};
        end
        return cnt;
    endfunction

    assign go_s = ~stage_stall;

    // Back-pressure chain, evaluated from the oldest stage toward the youngest.
    always_comb begin
        chain_s   = out_allowin;
        allowin_s = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            chain_s      = ~valid_r[k] | (go_s[k] & chain_s);
            allowin_s[k] = chain_s;
        end
    end

    // up_s[k] is the valid being offered into stage k by its producer.
    assign up_s        = {valid_r[STAGES-2:0] & go_s[STAGES-2:0], in_valid};
    assign load_s      = allowin_s & up_s & ~{STAGES{flush}};
    assign nxt_valid_s = flush ? {STAGES{1'b0}}
                               : ((allowin_s & up_s) | (~allowin_s & valid_r));

    assign in_allowin = allowin_s[0] & ~flush;
    assign out_valid  = valid_r[STAGES-1] & go_s[STAGES-1];
    assign out_data   = data_r[STAGES-1];
    assign out_wen    = wen_r[STAGES-1];
    assign out_wnum   = wnum_r[STAGES-1];

    // Valid vector and occupancy count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_r <= '0;
            occ     <= '0;
        end else begin
            valid_r <= nxt_valid_s;
            occ     <= popcount(nxt_valid_s);
        end
    end

    // Stage 0 loads from the input port; later stages copy their predecessor.
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_head
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    data_r[0] <= '0;
                    wen_r[0]  <= 1'b0;
                    wnum_r[0] <= 5'd0;
                    rdy_r[0]  <= '0;
                end else if (load_s[0]) begin
                    data_r[0] <= in_data;
                    wen_r[0]  <= in_wen;
                    wnum_r[0] <= in_wnum;
                    rdy_r[0]  <= in_rdy_stage;
                end
            end
        end else begin : g_body
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    data_r[k] <= '0;
                    wen_r[k]  <= 1'b0;
                    wnum_r[k] <= 5'd0;
                    rdy_r[k]  <= '0;
                end else if (load_s[k]) begin
                    data_r[k] <= data_r[k-1];
                    wen_r[k]  <= wen_r[k-1];
                    wnum_r[k] <= wnum_r[k-1];
                    rdy_r[k]  <= rdy_r[k-1];
                end
            end
        end
    end

    // Hazard lookup: scanning oldest-first lets the youngest match win.
    always_comb begin
        logic [4:0] rn;
        hit       = '0;
        hit_stage = '0;
        stall_req = '0;
        for (int i = 0; i < NREAD; i++) begin
            rn = rd_num[5*i +: 5];
            for (int k = STAGES - 1; k >= 0; k--) begin
                if (valid_r[k] && wen_r[k] && (wnum_r[k] == rn) && (rn != 5'd0)) begin
                    hit[i]               = 1'b1;
                    hit_stage[SW*i +: SW] = SW'(k);
                    stall_req[i]         = (rdy_r[k] > SW'(k));
                end else begin
                    hit[i] = hit[i];
                end
            end
        end
    end

endmodule
